// File: rtl/spec_acc_bgsub_peak.sv
// spec_acc_bgsub_peak: multi-pulse power-spectrum accumulator with background subtraction and per-bin peak search
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   start_i, acc_num_i                 start a group of acc_num_i pulses (0 counts as 1)
//   spec_valid_i/data_i/index_i        input spectrum stream, no backpressure
//   out_valid_o/ready_i/data/bin/index/last_o   corrected spectrum stream, valid/ready
//   peak_valid_o/bin/index/value_o     one peak record per range bin 1..NBINS-1
//   busy_o, sat_o, seq_err_o           status (sat/seq_err sticky until next start)
module spec_acc_bgsub_peak #(
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 40,
    parameter int NFFT    = 1024,
    parameter int NBINS   = 16,
    parameter int PULSE_W = 16,
    localparam int KW = $clog2(NFFT),
    localparam int BW = $clog2(NBINS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [PULSE_W-1:0] acc_num_i,
    input  logic               spec_valid_i,
    input  logic [DATA_W-1:0]  spec_data_i,
    input  logic [KW-1:0]      spec_index_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ACC_W-1:0]   out_data_o,
    output logic [BW-1:0]      out_bin_o,
    output logic [KW-1:0]      out_index_o,
    output logic               out_last_o,
    output logic               peak_valid_o,
    output logic [BW-1:0]      peak_bin_o,
    output logic [KW-1:0]      peak_index_o,
    output logic [ACC_W-1:0]   peak_value_o,
    output logic               busy_o,
    output logic               sat_o,
    output logic               seq_err_o
);
    localparam int AW = BW + KW;
    typedef enum logic [1:0] {IDLE, ACCUM, READ, DONE} state_t;
    typedef struct packed {
        logic             last;
        logic [BW-1:0]    bin;
        logic [KW-1:0]    idx;
        logic [ACC_W-1:0] data;
    } ent_t;

    logic [ACC_W-1:0] mem [NBINS*NFFT];
    state_t state_q, state_d;
    logic [PULSE_W-1:0] acc_num_q, acc_num_d, p_q, p_d;
    logic [KW-1:0] k_q, k_d, rk_q, rk_d, rv_idx_q, rv_idx_d, pk_idx_q, pk_idx_d, peak_index_q, peak_index_d;
    logic [BW-1:0] b_q, b_d, rb_q, rb_d, rv_bin_q, rv_bin_d, peak_bin_q, peak_bin_d;
    logic wr_pend_q, wr_pend_d, wr_first_q, wr_first_d, iss_done_q, iss_done_d;
    logic rv_q, rv_d, ov_q, ov_d, busy_q, busy_d, sat_q, sat_d, seq_err_q, seq_err_d, peak_valid_q, peak_valid_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d, ra;
    logic [ACC_W-1:0] wr_data_q, wr_data_d, rd_a_q, rd_b_q, wr_val, diff, nmax;
    logic [ACC_W-1:0] pk_max_q, pk_max_d, peak_value_q, peak_value_d;
    logic [ACC_W:0] sum;
    ent_t oe_q, oe_d, sk0_q, sk0_d, sk1_q, sk1_d, arr;
    logic [1:0] sk_cnt_q, sk_cnt_d;
    logic [2:0] occ;
    logic pop, issue, upd;

    // Second half of the read-modify-write: pulse 0 overwrites, later pulses add with saturation
    assign sum    = {1'b0, rd_a_q} + {1'b0, wr_data_q};
    assign wr_val = wr_first_q ? wr_data_q : (sum[ACC_W] ? '1 : sum[ACC_W-1:0]);
    assign ra     = state_q == ACCUM ? {b_q, spec_index_i} : {rb_q, rk_q};

    // Port A serves accumulation and the signal bin on read-out; port B reads the background bin
    always_ff @(posedge clk_i) begin
        if (wr_pend_q) mem[wr_addr_q] <= wr_val;
        rd_a_q <= (wr_pend_q && wr_addr_q == ra) ? wr_val : mem[ra];
        rd_b_q <= mem[{BW'(0), rk_q}];
    end

    // Read credits cover the output register, both skid slots and the word in the RAM pipeline
    assign pop   = ov_q && out_ready_i;
    assign occ   = 3'(ov_q) + 3'(sk_cnt_q) + 3'(rv_q);
    assign issue = state_q == READ && !iss_done_q && !wr_pend_q && occ - 3'(pop) < 3'd3;
    assign diff  = rd_a_q >= rd_b_q ? rd_a_q - rd_b_q : '0;
    assign arr   = {rv_bin_q == BW'(NBINS-1) && rv_idx_q == KW'(NFFT-1), rv_bin_q, rv_idx_q, diff};
    assign upd   = oe_q.idx == '0 || oe_q.data > pk_max_q;
    assign nmax  = upd ? oe_q.data : pk_max_q;

    always_comb begin
        state_d = state_q;
        acc_num_d = acc_num_q;
        p_d = p_q;
        k_d = k_q;
        b_d = b_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_first_d = wr_first_q;
        rb_d = rb_q;
        rk_d = rk_q;
        iss_done_d = iss_done_q;
        rv_d = issue;
        rv_bin_d = rv_bin_q;
        rv_idx_d = rv_idx_q;
        ov_d = ov_q;
        oe_d = oe_q;
        sk0_d = sk0_q;
        sk1_d = sk1_q;
        sk_cnt_d = sk_cnt_q;
        pk_max_d = pk_max_q;
        pk_idx_d = pk_idx_q;
        peak_valid_d = 1'b0;
        peak_bin_d = peak_bin_q;
        peak_index_d = peak_index_q;
        peak_value_d = peak_value_q;
        busy_d = busy_q;
        sat_d = sat_q | (wr_pend_q && !wr_first_q && sum[ACC_W]);
        seq_err_d = seq_err_q;
        if (state_q == IDLE && start_i) begin
            state_d = ACCUM;
            acc_num_d = acc_num_i == '0 ? PULSE_W'(1) : acc_num_i;
            p_d = '0;
            k_d = '0;
            b_d = '0;
            busy_d = 1'b1;
            sat_d = 1'b0;
            seq_err_d = 1'b0;
        end
        if (spec_valid_i && (state_q != ACCUM || spec_index_i != k_q)) seq_err_d = 1'b1;
        // A mismatched index resynchronises k; the word lands at its own index
        if (state_q == ACCUM && spec_valid_i) begin
            wr_pend_d = 1'b1;
            wr_addr_d = ra;
            wr_data_d = ACC_W'(spec_data_i);
            wr_first_d = p_q == '0;
            k_d = spec_index_i + 1'b1;
            if (spec_index_i == KW'(NFFT-1)) begin
                b_d = b_q + 1'b1;
                if (b_q == BW'(NBINS-1)) begin
                    p_d = p_q + 1'b1;
                    if (p_d == acc_num_q) begin
                        state_d = READ;
                        rb_d = BW'(1);
                        rk_d = '0;
                        iss_done_d = 1'b0;
                    end
                end
            end
        end
        if (issue) begin
            rv_bin_d = rb_q;
            rv_idx_d = rk_q;
            rk_d = rk_q + 1'b1;
            if (rk_q == KW'(NFFT-1)) begin
                rb_d = rb_q + 1'b1;
                iss_done_d = rb_q == BW'(NBINS-1);
            end
        end
        // Output register refills from the skid head first so word order is preserved
        if (!ov_q || pop) begin
            if (sk_cnt_q != 2'd0) begin
                ov_d = 1'b1;
                oe_d = sk0_q;
                sk0_d = sk1_q;
                if (rv_q) begin
                    if (sk_cnt_q == 2'd1) sk0_d = arr;
                    else sk1_d = arr;
                end else begin
                    sk_cnt_d = sk_cnt_q - 2'd1;
                end
            end else begin
                ov_d = rv_q;
                if (rv_q) oe_d = arr;
            end
        end else if (rv_q) begin
            if (sk_cnt_q == 2'd0) sk0_d = arr;
            else sk1_d = arr;
            sk_cnt_d = sk_cnt_q + 2'd1;
        end
        // Strict greater-than keeps the lowest index on ties; k=0 restarts the search
        if (pop) begin
            pk_max_d = nmax;
            pk_idx_d = upd ? oe_q.idx : pk_idx_q;
            if (oe_q.idx == KW'(NFFT-1)) begin
                peak_valid_d = 1'b1;
                peak_bin_d = oe_q.bin;
                peak_index_d = pk_idx_d;
                peak_value_d = nmax;
            end
            if (oe_q.last) begin
                state_d = DONE;
                busy_d = 1'b0;
            end
        end
        if (state_q == DONE) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_num_q <= '0;
            p_q <= '0;
            k_q <= '0;
            b_q <= '0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_first_q <= 1'b0;
            rb_q <= '0;
            rk_q <= '0;
            iss_done_q <= 1'b0;
            rv_q <= 1'b0;
            rv_bin_q <= '0;
            rv_idx_q <= '0;
            ov_q <= 1'b0;
            oe_q <= '0;
            sk0_q <= '0;
            sk1_q <= '0;
            sk_cnt_q <= '0;
            pk_max_q <= '0;
            pk_idx_q <= '0;
            peak_valid_q <= 1'b0;
            peak_bin_q <= '0;
            peak_index_q <= '0;
            peak_value_q <= '0;
            busy_q <= 1'b0;
            sat_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_num_q <= acc_num_d;
            p_q <= p_d;
            k_q <= k_d;
            b_q <= b_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_first_q <= wr_first_d;
            rb_q <= rb_d;
            rk_q <= rk_d;
            iss_done_q <= iss_done_d;
            rv_q <= rv_d;
            rv_bin_q <= rv_bin_d;
            rv_idx_q <= rv_idx_d;
            ov_q <= ov_d;
            oe_q <= oe_d;
            sk0_q <= sk0_d;
            sk1_q <= sk1_d;
            sk_cnt_q <= sk_cnt_d;
            pk_max_q <= pk_max_d;
            pk_idx_q <= pk_idx_d;
            peak_valid_q <= peak_valid_d;
            peak_bin_q <= peak_bin_d;
            peak_index_q <= peak_index_d;
            peak_value_q <= peak_value_d;
            busy_q <= busy_d;
            sat_q <= sat_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign out_valid_o  = ov_q;
    assign out_data_o   = oe_q.data;
    assign out_bin_o    = oe_q.bin;
    assign out_index_o  = oe_q.idx;
    assign out_last_o   = ov_q && oe_q.last;
    assign peak_valid_o = peak_valid_q;
    assign peak_bin_o   = peak_bin_q;
    assign peak_index_o = peak_index_q;
    assign peak_value_o = peak_value_q;
    assign busy_o       = busy_q;
    assign sat_o        = sat_q;
    assign seq_err_o    = seq_err_q;
endmodule

// File: tb/tb_spec_acc_bgsub_peak.sv
// tb_spec_acc_bgsub_peak: scoreboard bench for spec_acc_bgsub_peak with NFFT=8, NBINS=4, DATA_W=16, ACC_W=20
module tb_spec_acc_bgsub_peak;
    localparam int DW = 16, AW = 20, NF = 8, NB = 4, PW = 16;
    localparam longint AMAX = (64'd1 << AW) - 1;

    typedef struct {
        int     bin;
        int     idx;
        longint val;
        bit     last;
        bit     dc;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [PW-1:0] acc_num_i = '0;
    logic          spec_valid_i = 1'b0;
    logic [DW-1:0] spec_data_i = '0;
    logic [2:0]    spec_index_i = '0;
    logic          out_ready_i = 1'b1;
    logic          out_valid_o, out_last_o, peak_valid_o, busy_o, sat_o, seq_err_o;
    logic [AW-1:0] out_data_o, peak_value_o;
    logic [1:0]    out_bin_o, peak_bin_o;
    logic [2:0]    out_index_o, peak_index_o;

    exp_t oq[$];
    exp_t pq[$];
    exp_t me, pe;
    int   checks = 0, errors = 0, xfers = 0, cyc = 0;
    bit   bp_mode = 1'b0;
    bit   hold = 1'b0;
    logic [AW-1:0] h_data;
    logic [1:0]    h_bin;
    logic [2:0]    h_idx;
    logic          h_last;

    spec_acc_bgsub_peak #(.DATA_W(DW), .ACC_W(AW), .NFFT(NF), .NBINS(NB), .PULSE_W(PW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .acc_num_i(acc_num_i),
        .spec_valid_i(spec_valid_i), .spec_data_i(spec_data_i), .spec_index_i(spec_index_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_bin_o(out_bin_o), .out_index_o(out_index_o), .out_last_o(out_last_o),
        .peak_valid_o(peak_valid_o), .peak_bin_o(peak_bin_o), .peak_index_o(peak_index_o),
        .peak_value_o(peak_value_o), .busy_o(busy_o), .sat_o(sat_o), .seq_err_o(seq_err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;
    always @(posedge clk_i) begin
        #1;
        out_ready_i = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // scn 0: bin0=5, bin b word k = 10b+k; scn 1: all 0xFFFF; scn 2: bin0=100, bin1=40, bins 2,3 = 150+k
    function automatic longint din(int scn, int b, int k);
        if (scn == 1) return 65535;
        if (scn == 2) return b == 0 ? 100 : (b == 1 ? 40 : 150 + k);
        return b == 0 ? 5 : 10 * b + k;
    endfunction

    function automatic longint acc(int scn, int n, int b, int k);
        longint s;
        s = longint'(n == 0 ? 1 : n) * din(scn, b, k);
        return s > AMAX ? AMAX : s;
    endfunction

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(int scn, int n, int dcb, int dck);
        for (int b = 1; b < NB; b++) begin
            longint mx = 0;
            int mi = 0;
            for (int k = 0; k < NF; k++) begin
                longint v = acc(scn, n, b, k) - acc(scn, n, 0, k);
                if (v < 0) v = 0;
                oq.push_back('{b, k, v, b == NB - 1 && k == NF - 1, b == dcb && k == dck});
                if (k == 0 || v > mx) begin
                    mx = v;
                    mi = k;
                end
            end
            pq.push_back('{b, mi, mx, 1'b0, b == dcb});
        end
    endtask

    task automatic run_accum(int scn, int n, int skb, int skk, bit poke);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        acc_num_i = PW'(n);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int p = 0; p < (n == 0 ? 1 : n); p++)
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < NF; k++) begin
                    if (p == 0 && b == skb && k == skk) continue;
                    spec_valid_i = 1'b1;
                    spec_data_i = DW'(din(scn, b, k));
                    spec_index_i = 3'(k);
                    start_i = poke && p == 0 && b == 1 && k == 2;
                    if (start_i) acc_num_i = 7;
                    @(posedge clk_i); #1;
                end
        spec_valid_i = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic wait_done(string name);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(posedge clk_i); #2;
            if (!busy_o && oq.size() == 0 && pq.size() == 0) break;
        end
        checks++;
        if (i == 4000) begin
            errors++;
            $display("FAIL %s_done: got busy=%0d words_left=%0d peaks_left=%0d expected 0 0 0", name, busy_o, oq.size(), pq.size());
        end
    endtask

    task automatic wait_xfer(int target, output int at);
        int i;
        at = -1;
        for (i = 0; i < 2000; i++) begin
            @(posedge clk_i); #2;
            if (xfers >= target) break;
        end
        checks++;
        if (i == 2000) begin
            errors++;
            $display("FAIL xfer_wait: got %0d transfers expected %0d", xfers, target);
        end else at = cyc;
    endtask

    always @(negedge clk_i) begin
        if (rst_i) hold = 1'b0;
        else begin
            if (hold) begin
                checks++;
                if (!out_valid_o || out_data_o != h_data || out_bin_o != h_bin || out_index_o != h_idx || out_last_o != h_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0d d=%0d b=%0d k=%0d l=%0d expected v=1 d=%0d b=%0d k=%0d l=%0d",
                             out_valid_o, out_data_o, out_bin_o, out_index_o, out_last_o, h_data, h_bin, h_idx, h_last);
                end
            end
            if (out_valid_o && out_ready_i) begin
                xfers++;
                checks++;
                if (oq.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra: got b=%0d k=%0d d=%0d expected no word", out_bin_o, out_index_o, out_data_o);
                end else begin
                    me = oq.pop_front();
                    if (int'(out_bin_o) != me.bin || int'(out_index_o) != me.idx || out_last_o != me.last ||
                        (!me.dc && longint'(out_data_o) != me.val)) begin
                        errors++;
                        $display("FAIL out_word: got b=%0d k=%0d d=%0d l=%0d expected b=%0d k=%0d d=%0d l=%0d",
                                 out_bin_o, out_index_o, out_data_o, out_last_o, me.bin, me.idx, me.val, me.last);
                    end
                end
            end
            hold = out_valid_o && !out_ready_i;
            h_data = out_data_o;
            h_bin = out_bin_o;
            h_idx = out_index_o;
            h_last = out_last_o;
            if (peak_valid_o) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL peak_extra: got b=%0d k=%0d v=%0d expected no record", peak_bin_o, peak_index_o, peak_value_o);
                end else begin
                    pe = pq.pop_front();
                    if (int'(peak_bin_o) != pe.bin || (!pe.dc && (int'(peak_index_o) != pe.idx || longint'(peak_value_o) != pe.val))) begin
                        errors++;
                        $display("FAIL peak: got b=%0d k=%0d v=%0d expected b=%0d k=%0d v=%0d",
                                 peak_bin_o, peak_index_o, peak_value_o, pe.bin, pe.idx, pe.val);
                    end
                end
            end
        end
    end

    initial begin
        int c0, c1, base;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_out_last", out_last_o, 0);
        chk("rst_peak_valid", peak_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_seq_err", seq_err_o, 0);
        rst_i = 1'b0;

        push_exp(0, 3, -1, -1);
        base = xfers;
        run_accum(0, 3, -1, -1, 1'b0);
        chk("s1_busy", busy_o, 1);
        wait_xfer(base + 1, c0);
        wait_xfer(base + 24, c1);
        chk("s1_span", c1 - c0, 23);
        wait_done("s1");
        chk("s1_sat", sat_o, 0);
        chk("s1_seq_err", seq_err_o, 0);

        push_exp(1, 17, -1, -1);
        run_accum(1, 17, -1, -1, 1'b0);
        wait_done("sat");
        chk("sat_sat", sat_o, 1);
        chk("sat_seq_err", seq_err_o, 0);

        push_exp(2, 0, -1, -1);
        run_accum(2, 0, -1, -1, 1'b0);
        wait_done("clamp");
        chk("clamp_sat", sat_o, 0);

        bp_mode = 1'b1;
        push_exp(0, 3, -1, -1);
        run_accum(0, 3, -1, -1, 1'b0);
        wait_done("bp");
        bp_mode = 1'b0;

        push_exp(0, 1, 2, 3);
        run_accum(0, 1, 2, 3, 1'b0);
        wait_done("seq");
        chk("seq_seq_err", seq_err_o, 1);

        push_exp(0, 3, -1, -1);
        base = xfers;
        run_accum(0, 3, -1, -1, 1'b0);
        wait_xfer(base + 5, c0);
        rst_i = 1'b1;
        #1;
        oq.delete();
        pq.delete();
        chk("mid_rst_out_valid", out_valid_o, 0);
        chk("mid_rst_out_data", out_data_o, 0);
        chk("mid_rst_peak_valid", peak_valid_o, 0);
        chk("mid_rst_peak_value", peak_value_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        push_exp(0, 3, -1, -1);
        run_accum(0, 3, -1, -1, 1'b1);
        wait_done("after_rst");
        chk("after_rst_seq_err", seq_err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
